// File: rtl/sdram_write.sv
// -----------------------------------------------------------------------------
// sdram_write
//
// Write-burst engine for the single-bank SDRAM controller. A key_wr pulse
// raises wr_req towards the top-level arbiter. Once the arbiter moves into
// the WRITE state, the block runs a fixed 14-cycle command schedule:
// PRE / ACT (only when a row has to be opened), then one WR command. It
// follows with a 4-word burst pulled from an upstream show-ahead-off FIFO.
// When the burst completes, the linear row/column address advances.
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous, active-high reset
//   wr_en       in   arbiter grant pulse, clears wr_req
//   state       in   arbiter state code; active while state == WRITE
//   ref_req     in   refresh request pending at the arbiter
//   key_wr      in   write trigger pulse
//   wr_data     in   FIFO read data, valid one cycle after wr_data_rd
//   sdram_cmd   out  {CS_N,RAS_N,CAS_N,WE_N}
//   sdram_addr  out  SDRAM address bus
//   sdram_bank  out  bank select (always bank 0)
//   wr_dq       out  write data towards the DQ tristate
//   wr_dq_oe    out  DQ output enable
//   wr_data_rd  out  FIFO read strobe
//   wr_req      out  write request to the arbiter
//   flag_wr_end out  one-cycle burst-complete pulse
// -----------------------------------------------------------------------------
module sdram_write #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [5:0]        state,
  input  logic              ref_req,
  input  logic              key_wr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [3:0]        sdram_cmd,
  output logic [11:0]       sdram_addr,
  output logic [1:0]        sdram_bank,
  output logic [DATA_W-1:0] wr_dq,
  output logic              wr_dq_oe,
  output logic              wr_data_rd,
  output logic              wr_req,
  output logic              flag_wr_end
);

  localparam logic [8:0]  COL_END = 9'd508;
  localparam logic [11:0] ROW_END = 12'd4095;
  localparam logic [5:0]  WRITE   = 6'b00_1000;
  localparam logic [3:0]  CMD_END = 4'd12;

  localparam logic [3:0]  CMD_NOP = 4'b0111;
  localparam logic [3:0]  CMD_PRE = 4'b0010;
  localparam logic [3:0]  CMD_ACT = 4'b0011;
  localparam logic [3:0]  CMD_WR  = 4'b0100;

  // Schedule points, expressed as cmd_cnt values.
  localparam logic [3:0]  K_PRE     = 4'd3;
  localparam logic [3:0]  K_ACT     = 4'd5;
  localparam logic [3:0]  K_WR      = 4'd7;
  localparam logic [3:0]  K_RD_FST  = 4'd5;
  localparam logic [3:0]  K_RD_LST  = 4'd8;
  localparam logic [3:0]  K_OE_FST  = 4'd7;
  localparam logic [3:0]  K_OE_LST  = 4'd10;

  // Registered state and outputs.
  logic [3:0]        cmd_cnt_q,     cmd_cnt_d;
  logic [8:0]        col_addr_q,    col_addr_d;
  logic [11:0]       row_addr_q,    row_addr_d;
  logic              flag_act_q,    flag_act_d;
  logic [3:0]        sdram_cmd_q,   sdram_cmd_d;
  logic [11:0]       sdram_addr_q,  sdram_addr_d;
  logic [1:0]        sdram_bank_q,  sdram_bank_d;
  logic [DATA_W-1:0] wr_dq_q,       wr_dq_d;
  logic              wr_dq_oe_q,    wr_dq_oe_d;
  logic              wr_data_rd_q,  wr_data_rd_d;
  logic              wr_req_q,      wr_req_d;
  logic              flag_wr_end_q, flag_wr_end_d;

  logic active;
  logic newrow;

  // ---------------------------------------------------------------------------
  // Next-state logic.
  //
  // Every output register is loaded from cmd_cnt_d, the value cmd_cnt takes
  // in the same cycle as the output. An output belonging to cycle Ck is
  // therefore visible exactly while cmd_cnt == k. Because cmd_cnt_d is forced
  // to 0 whenever state leaves WRITE, an abort turns everything back to
  // NOP / oe=0 / rd=0 on the very next cycle without extra logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    active = (state == WRITE);

    // Burst cycle counter: runs while active, parks at CMD_END+1, never wraps.
    cmd_cnt_d = 4'd0;
    if (active) begin
      if (cmd_cnt_q > CMD_END) cmd_cnt_d = cmd_cnt_q;
      else                     cmd_cnt_d = cmd_cnt_q + 4'd1;
    end

    // A row must be (re)opened at the start of every row. It must also be
    // reopened after a refresh has closed all banks between two bursts.
    newrow = (col_addr_q == 9'd0) || flag_act_q;

    sdram_cmd_d  = CMD_NOP;
    sdram_addr_d = row_addr_q;
    sdram_bank_d = 2'd0;
    unique case (cmd_cnt_d)
      K_PRE: begin
        if (newrow) begin
          sdram_cmd_d  = CMD_PRE;
          sdram_addr_d = 12'h400;            // A10=1: precharge all banks
        end
      end
      K_ACT: begin
        if (newrow) sdram_cmd_d = CMD_ACT;   // row address on the bus
      end
      K_WR: begin
        sdram_cmd_d  = CMD_WR;
        sdram_addr_d = {3'b000, col_addr_q}; // A10=0: no auto-precharge
      end
      default: ;
    endcase

    // The FIFO is not show-ahead: data appears one cycle after the strobe.
    // A strobe in C5..C8 therefore delivers words that are captured at the
    // ends of C6..C9 and driven on DQ in C7..C10.
    wr_data_rd_d = (cmd_cnt_d >= K_RD_FST) && (cmd_cnt_d <= K_RD_LST);
    wr_dq_oe_d   = (cmd_cnt_d >= K_OE_FST) && (cmd_cnt_d <= K_OE_LST);
    wr_dq_d      = wr_dq_oe_d ? wr_data : wr_dq_q;

    // Fires only on the CMD_END -> CMD_END+1 step, so the parked counter
    // does not re-trigger it.
    flag_wr_end_d = active && (cmd_cnt_q == CMD_END);

    // Grant wins over a simultaneous trigger; triggers during WRITE are ignored.
    wr_req_d = wr_req_q;
    if (wr_en)                    wr_req_d = 1'b0;
    else if (key_wr && !active)   wr_req_d = 1'b1;

    // Address advance and row-reopen bookkeeping on burst completion.
    col_addr_d = col_addr_q;
    row_addr_d = row_addr_q;
    flag_act_d = flag_act_q;
    if (flag_wr_end_q) begin
      flag_act_d = ref_req;
      if (col_addr_q == COL_END) begin
        col_addr_d = 9'd0;
        if (row_addr_q == ROW_END) row_addr_d = 12'd0;
        else                       row_addr_d = row_addr_q + 12'd1;
      end else begin
        col_addr_d = col_addr_q + 9'd4;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register stage.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_cnt_q     <= 4'd0;
      col_addr_q    <= 9'd0;
      row_addr_q    <= 12'd0;
      flag_act_q    <= 1'b0;
      sdram_cmd_q   <= CMD_NOP;
      sdram_addr_q  <= 12'd0;
      sdram_bank_q  <= 2'd0;
      wr_dq_q       <= '0;
      wr_dq_oe_q    <= 1'b0;
      wr_data_rd_q  <= 1'b0;
      wr_req_q      <= 1'b0;
      flag_wr_end_q <= 1'b0;
    end else begin
      cmd_cnt_q     <= cmd_cnt_d;
      col_addr_q    <= col_addr_d;
      row_addr_q    <= row_addr_d;
      flag_act_q    <= flag_act_d;
      sdram_cmd_q   <= sdram_cmd_d;
      sdram_addr_q  <= sdram_addr_d;
      sdram_bank_q  <= sdram_bank_d;
      wr_dq_q       <= wr_dq_d;
      wr_dq_oe_q    <= wr_dq_oe_d;
      wr_data_rd_q  <= wr_data_rd_d;
      wr_req_q      <= wr_req_d;
      flag_wr_end_q <= flag_wr_end_d;
    end
  end

  assign sdram_cmd   = sdram_cmd_q;
  assign sdram_addr  = sdram_addr_q;
  assign sdram_bank  = sdram_bank_q;
  assign wr_dq       = wr_dq_q;
  assign wr_dq_oe    = wr_dq_oe_q;
  assign wr_data_rd  = wr_data_rd_q;
  assign wr_req      = wr_req_q;
  assign flag_wr_end = flag_wr_end_q;

endmodule

// File: tb/tb_sdram_write.sv
// -----------------------------------------------------------------------------
// tb_sdram_write
//
// Directed bench for sdram_write. The first burst is checked cycle by cycle
// against a table of hand-computed vectors. Hand-written sequences cover the
// request handshake, row reopen after refresh, address wrap, abort and
// mid-burst reset.
// -----------------------------------------------------------------------------
module tb_sdram_write;

  localparam logic [5:0] WRITE = 6'b00_1000;
  localparam logic [3:0] NOP   = 4'b0111;
  localparam logic [3:0] PRE   = 4'b0010;
  localparam logic [3:0] ACT   = 4'b0011;
  localparam logic [3:0] WR    = 4'b0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [5:0]  state;
  logic        ref_req;
  logic        key_wr;
  logic [15:0] wr_data;
  logic [3:0]  sdram_cmd;
  logic [11:0] sdram_addr;
  logic [1:0]  sdram_bank;
  logic [15:0] wr_dq;
  logic        wr_dq_oe;
  logic        wr_data_rd;
  logic        wr_req;
  logic        flag_wr_end;

  sdram_write dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .state      (state),
    .ref_req    (ref_req),
    .key_wr     (key_wr),
    .wr_data    (wr_data),
    .sdram_cmd  (sdram_cmd),
    .sdram_addr (sdram_addr),
    .sdram_bank (sdram_bank),
    .wr_dq      (wr_dq),
    .wr_dq_oe   (wr_dq_oe),
    .wr_data_rd (wr_data_rd),
    .wr_req     (wr_req),
    .flag_wr_end(flag_wr_end)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Per-cycle capture of one burst, indexed by cycle number k.
  logic [3:0]  cmd_r  [16];
  logic [11:0] addr_r [16];
  logic [15:0] dq_r   [16];
  logic        oe_r   [16];
  logic        rd_r   [16];
  logic        flag_r [16];
  logic        req_r  [16];
  logic [1:0]  bank_r [16];

  typedef struct {
    logic [3:0]  cmd;
    logic [11:0] addr;
    logic        oe;
    logic        rd;
    logic        flag;
    logic [15:0] dq;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Runs one burst: state goes to WRITE at a falling edge, which is inside C0.
  // Outputs are captured 1ns after each rising edge for C1..C15. The FIFO
  // returns base+n one cycle after each strobe. ref_req is driven with ref_val
  // in C13. The task drops state in cycle drop_k and pulses rst in cycle rst_k
  // (negative values disable either action).
  task automatic run_burst(input logic [15:0] base, input logic ref_val,
                           input int drop_k, input int rst_k);
    int   fidx;
    logic rd_prev;
    fidx    = 0;
    rd_prev = 1'b0;
    @(negedge clk);
    state   = WRITE;
    ref_req = 1'b0;
    cmd_r[0] = sdram_cmd; addr_r[0] = sdram_addr; dq_r[0] = wr_dq;
    oe_r[0] = wr_dq_oe; rd_r[0] = wr_data_rd; flag_r[0] = flag_wr_end;
    req_r[0] = wr_req; bank_r[0] = sdram_bank;
    for (int k = 1; k < 16; k++) begin
      @(posedge clk);
      #1;
      if (rd_prev) begin
        wr_data = base + 16'(fidx);
        fidx++;
      end
      if (k == drop_k) state = 6'd0;
      rst     = (k == rst_k);
      ref_req = (k == 13) ? ref_val : 1'b0;
      cmd_r[k] = sdram_cmd; addr_r[k] = sdram_addr; dq_r[k] = wr_dq;
      oe_r[k] = wr_dq_oe; rd_r[k] = wr_data_rd; flag_r[k] = flag_wr_end;
      req_r[k] = wr_req; bank_r[k] = sdram_bank;
      rd_prev = wr_data_rd;
    end
    @(negedge clk);
    state   = 6'd0;
    ref_req = 1'b0;
    rst     = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // Expected first burst: row 0, col 0, so a row open is required.
    tbl[0]  = '{NOP, 12'h000, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[1]  = '{NOP, 12'h000, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[2]  = '{NOP, 12'h000, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[3]  = '{PRE, 12'h400, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[4]  = '{NOP, 12'h000, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[5]  = '{ACT, 12'h000, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[6]  = '{NOP, 12'h000, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[7]  = '{WR,  12'h000, 1'b1, 1'b1, 1'b0, 16'hA000};
    tbl[8]  = '{NOP, 12'h000, 1'b1, 1'b1, 1'b0, 16'hA001};
    tbl[9]  = '{NOP, 12'h000, 1'b1, 1'b0, 1'b0, 16'hA002};
    tbl[10] = '{NOP, 12'h000, 1'b1, 1'b0, 1'b0, 16'hA003};
    tbl[11] = '{NOP, 12'h000, 1'b0, 1'b0, 1'b0, 16'hA003};
    tbl[12] = '{NOP, 12'h000, 1'b0, 1'b0, 1'b0, 16'hA003};
    tbl[13] = '{NOP, 12'h000, 1'b0, 1'b0, 1'b1, 16'hA003};
    tbl[14] = '{NOP, 12'h000, 1'b0, 1'b0, 1'b0, 16'hA003};
    tbl[15] = '{NOP, 12'h000, 1'b0, 1'b0, 1'b0, 16'hA003};

    rst = 1'b1; wr_en = 1'b0; state = 6'd0; ref_req = 1'b0;
    key_wr = 1'b0; wr_data = 16'h0;

    // Reset, then idle.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst addr", 32'(sdram_addr), 32'h0);
    check("rst bank", 32'(sdram_bank), 32'h0);
    check("rst dq", 32'(wr_dq), 32'h0);
    check("rst oe", 32'(wr_dq_oe), 32'h0);
    check("rst rd", 32'(wr_data_rd), 32'h0);
    check("rst req", 32'(wr_req), 32'h0);
    check("rst flag", 32'(flag_wr_end), 32'h0);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("idle cmd %0d", i), 32'(sdram_cmd), 32'(NOP));
      @(negedge clk);
    end

    // Request handshake: key_wr, then wr_en three cycles later.
    key_wr = 1'b1;
    @(negedge clk); key_wr = 1'b0;
    check("req rise", 32'(wr_req), 32'h1);
    @(negedge clk);
    check("req hold", 32'(wr_req), 32'h1);
    @(negedge clk); wr_en = 1'b1;
    check("req before en", 32'(wr_req), 32'h1);
    @(negedge clk); wr_en = 1'b0;
    check("req fall", 32'(wr_req), 32'h0);
    key_wr = 1'b1; wr_en = 1'b1;
    @(negedge clk); key_wr = 1'b0; wr_en = 1'b0;
    check("req key+en", 32'(wr_req), 32'h0);
    state = WRITE; key_wr = 1'b1;
    @(negedge clk); key_wr = 1'b0; state = 6'd0;
    check("req key in WRITE", 32'(wr_req), 32'h0);
    repeat (3) @(negedge clk);

    // Burst 1: full table comparison.
    run_burst(16'hA000, 1'b0, -1, -1);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("b1 cmd C%0d", k),  32'(cmd_r[k]),  32'(tbl[k].cmd));
      check($sformatf("b1 addr C%0d", k), 32'(addr_r[k]), 32'(tbl[k].addr));
      check($sformatf("b1 oe C%0d", k),   32'(oe_r[k]),   32'(tbl[k].oe));
      check($sformatf("b1 rd C%0d", k),   32'(rd_r[k]),   32'(tbl[k].rd));
      check($sformatf("b1 flag C%0d", k), 32'(flag_r[k]), 32'(tbl[k].flag));
      check($sformatf("b1 dq C%0d", k),   32'(dq_r[k]),   32'(tbl[k].dq));
      check($sformatf("b1 bank C%0d", k), 32'(bank_r[k]), 32'h0);
      check($sformatf("b1 req C%0d", k),  32'(req_r[k]),  32'h0);
    end
    check("b1 col after", 32'(dut.col_addr_q), 32'd4);

    // Burst 2: same row, no reopen; refresh pending at its end.
    run_burst(16'hB000, 1'b1, -1, -1);
    check("b2 cmd C3", 32'(cmd_r[3]), 32'(NOP));
    check("b2 cmd C5", 32'(cmd_r[5]), 32'(NOP));
    check("b2 cmd C7", 32'(cmd_r[7]), 32'(WR));
    check("b2 addr C7", 32'(addr_r[7]), 32'h004);
    check("b2 dq C7", 32'(dq_r[7]), 32'hB000);
    check("b2 dq C10", 32'(dq_r[10]), 32'hB003);
    check("b2 flag C13", 32'(flag_r[13]), 32'h1);

    // Burst 3: refresh cut in, so row 0 is reopened at col 8.
    run_burst(16'hC000, 1'b0, -1, -1);
    check("b3 cmd C3", 32'(cmd_r[3]), 32'(PRE));
    check("b3 addr C3", 32'(addr_r[3]), 32'h400);
    check("b3 cmd C5", 32'(cmd_r[5]), 32'(ACT));
    check("b3 addr C5", 32'(addr_r[5]), 32'h000);
    check("b3 addr C7", 32'(addr_r[7]), 32'h008);

    // Wrap: last column of last row.
    @(negedge clk);
    force dut.row_addr_q = 12'd4095;
    force dut.col_addr_q = 9'd508;
    @(negedge clk);
    release dut.row_addr_q;
    release dut.col_addr_q;
    run_burst(16'hD000, 1'b0, -1, -1);
    check("wrap cmd C3", 32'(cmd_r[3]), 32'(NOP));
    check("wrap addr C4", 32'(addr_r[4]), 32'hFFF);
    check("wrap cmd C5", 32'(cmd_r[5]), 32'(NOP));
    check("wrap addr C7", 32'(addr_r[7]), 32'h1FC);
    check("wrap row after", 32'(dut.row_addr_q), 32'd0);
    check("wrap col after", 32'(dut.col_addr_q), 32'd0);
    run_burst(16'hE000, 1'b0, -1, -1);
    check("post-wrap cmd C3", 32'(cmd_r[3]), 32'(PRE));
    check("post-wrap cmd C5", 32'(cmd_r[5]), 32'(ACT));
    check("post-wrap addr C5", 32'(addr_r[5]), 32'h000);
    check("post-wrap addr C7", 32'(addr_r[7]), 32'h000);

    // Abort: state drops in C8.
    run_burst(16'hF000, 1'b0, 8, -1);
    check("abort rd C8", 32'(rd_r[8]), 32'h1);
    check("abort oe C8", 32'(oe_r[8]), 32'h1);
    for (int k = 9; k < 16; k++) begin
      check($sformatf("abort cmd C%0d", k),  32'(cmd_r[k]),  32'(NOP));
      check($sformatf("abort oe C%0d", k),   32'(oe_r[k]),   32'h0);
      check($sformatf("abort rd C%0d", k),   32'(rd_r[k]),   32'h0);
      check($sformatf("abort flag C%0d", k), 32'(flag_r[k]), 32'h0);
    end
    check("abort dq hold", 32'(dq_r[12]), 32'hF001);
    check("abort col", 32'(dut.col_addr_q), 32'd4);

    // Reset in C6 of a burst; state leaves WRITE in C7.
    run_burst(16'h1234, 1'b0, 7, 6);
    check("mid rst pre dq", 32'(dq_r[6]), 32'hF001);
    check("mid rst cmd C7", 32'(cmd_r[7]), 32'(NOP));
    check("mid rst addr C7", 32'(addr_r[7]), 32'h0);
    check("mid rst bank C7", 32'(bank_r[7]), 32'h0);
    check("mid rst dq C7", 32'(dq_r[7]), 32'h0);
    check("mid rst oe C7", 32'(oe_r[7]), 32'h0);
    check("mid rst rd C7", 32'(rd_r[7]), 32'h0);
    check("mid rst req C7", 32'(req_r[7]), 32'h0);
    check("mid rst flag C7", 32'(flag_r[7]), 32'h0);
    check("mid rst col", 32'(dut.col_addr_q), 32'd0);
    check("mid rst row", 32'(dut.row_addr_q), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
